// File: rtl/prio_rr_encoder_if.sv
// Request/grant bundle for prio_rr_encoder: request side inputs plus the registered grant
// outputs and the round-robin pointer.
interface prio_rr_encoder_if #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = $clog2(N)
);
    logic [N-1:0]     req;
    logic             rr_en;
    logic             out_ready;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic [N-1:0]     out_onehot;
    logic [IDX_W-1:0] ptr;

    modport master (
        output req,
        output rr_en,
        output out_ready,
        input  out_valid,
        input  out_idx,
        input  out_onehot,
        input  ptr
    );

    modport slave (
        input  req,
        input  rr_en,
        input  out_ready,
        output out_valid,
        output out_idx,
        output out_onehot,
        output ptr
    );
endinterface

// File: rtl/prio_rr_encoder.sv
// Registered N-to-log2(N) priority encoder with a sticky grant and valid/ready handshake.
// Fixed mode favours bit N-1; round-robin mode rotates the top priority below each accepted grant.
module prio_rr_encoder #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input logic              clk,
    input logic              rst,
    prio_rr_encoder_if.slave bus
);

    typedef enum logic {StIdle, StHold} state_e;

    localparam logic [IDX_W-1:0] TopIdx = IDX_W'(N - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     onehot_q, onehot_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic             accept;
    logic             any_req;
    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] cand;

    // First set request scanning downward from start, wrapping from 0 to N-1.
    function automatic logic [IDX_W-1:0] sel(input logic [N-1:0]     r,
                                             input logic [IDX_W-1:0] from);
        logic [IDX_W-1:0] res;
        logic [IDX_W-1:0] kk;
        logic             found;
        int               k;
        res   = from;
        found = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            k = int'(from) - i;
            if (k < 0) begin
                k = k + int'(N);
            end
            kk = k[IDX_W-1:0];
            if (!found && r[kk]) begin
                found = 1'b1;
                res   = kk;
            end
        end
        return res;
    endfunction

    function automatic logic [N-1:0] decode(input logic [IDX_W-1:0] idx);
        logic [N-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    assign any_req = |bus.req;
    assign accept  = (state_q == StHold) && bus.out_ready;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        ptr_d    = ptr_q;

        if (accept && bus.rr_en) begin
            ptr_d = (idx_q == '0) ? TopIdx : idx_q - IDX_W'(1);
        end

        // The updated pointer seeds the scan so back-to-back grants already rotate.
        start = bus.rr_en ? ptr_d : TopIdx;
        cand  = sel(bus.req, start);

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d  = StHold;
                    idx_d    = cand;
                    onehot_d = decode(cand);
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    if (any_req) begin
                        idx_d    = cand;
                        onehot_d = decode(cand);
                    end else begin
                        state_d  = StIdle;
                        onehot_d = '0;
                    end
                end
            end
            default: begin
                state_d  = StIdle;
                onehot_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            onehot_q <= '0;
            ptr_q    <= TopIdx;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            ptr_q    <= ptr_d;
        end
    end

    assign bus.out_valid  = (state_q == StHold);
    assign bus.out_idx    = idx_q;
    assign bus.out_onehot = onehot_q;
    assign bus.ptr        = ptr_q;

endmodule

// File: tb/tb_prio_rr_encoder.sv
// Directed and randomized bench for prio_rr_encoder (N = 8) against a behavioural grant model.
module tb_prio_rr_encoder;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    // Reference model state
    bit   m_valid;
    int   m_idx;
    int   m_ptr;

    prio_rr_encoder_if #(.N(8)) bus ();

    prio_rr_encoder #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int ref_sel(input logic [7:0] r, input int from);
        for (int i = 0; i < 8; i++) begin
            int k;
            k = (from - i + 8) % 8;
            if (r[k]) return k;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the grant rules, compare all outputs.
    task automatic step(input logic r, input logic [7:0] rq, input logic rr, input logic rd);
        int start;
        rst           = r;
        bus.req       = rq;
        bus.rr_en     = rr;
        bus.out_ready = rd;
        @(posedge clk);
        if (r) begin
            m_valid = 0;
            m_idx   = 0;
            m_ptr   = 7;
        end else if (!m_valid) begin
            if (rq != 0) begin
                start   = rr ? m_ptr : 7;
                m_idx   = ref_sel(rq, start);
                m_valid = 1;
            end
        end else if (rd) begin
            if (rr) m_ptr = (m_idx + 7) % 8;
            if (rq != 0) begin
                start = rr ? m_ptr : 7;
                m_idx = ref_sel(rq, start);
            end else begin
                m_valid = 0;
            end
        end
        #1;
        chk("valid", 32'(bus.out_valid), 32'(m_valid));
        chk("idx", 32'(bus.out_idx), 32'(m_idx));
        chk("onehot", 32'(bus.out_onehot), m_valid ? (32'd1 << m_idx) : 32'd0);
        chk("ptr", 32'(bus.ptr), 32'(m_ptr));
    endtask

    initial begin
        logic [7:0] rq;
        int         exp_seq[9];
        clk           = 0;
        rst           = 1;
        checks        = 0;
        failures      = 0;
        m_valid       = 0;
        m_idx         = 0;
        m_ptr         = 7;
        bus.req       = '0;
        bus.rr_en     = 0;
        bus.out_ready = 0;

        // Reset with all requests active, then release
        step(1, 8'hFF, 0, 0);
        step(1, 8'hFF, 0, 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_ptr", 32'(bus.ptr), 7);
        step(0, 8'hFF, 0, 0);
        chk("rel_idx", 32'(bus.out_idx), 7);

        // Fixed priority with continuous accept
        for (int i = 0; i < 4; i++) begin
            step(0, 8'b0010_0110, 0, 1);
            chk("fixed_idx", 32'(bus.out_idx), 5);
            chk("fixed_ptr", 32'(bus.ptr), 7);
        end
        for (int i = 0; i < 256; i++) step(0, 8'(i), 0, 1);

        // Backpressure: held grant survives request change
        step(0, 8'h00, 0, 1);
        step(0, 8'h81, 0, 0);
        chk("bp_idx", 32'(bus.out_idx), 7);
        step(0, 8'h01, 0, 0);
        chk("bp_sticky", 32'(bus.out_idx), 7);
        step(0, 8'h01, 1, 0);
        chk("bp_rr_sticky", 32'(bus.out_idx), 7);
        step(0, 8'h01, 0, 1);
        chk("bp_next", 32'(bus.out_idx), 0);
        step(0, 8'h00, 0, 1);
        chk("bp_idle", 32'(bus.out_valid), 0);

        // Round-robin full rotation
        step(1, 8'h00, 0, 0);
        exp_seq = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        for (int i = 0; i < 9; i++) begin
            step(0, 8'hFF, 1, 1);
            chk("rr_seq", 32'(bus.out_idx), 32'(exp_seq[i]));
        end

        // Round-robin alternation between two sources, then fixed mode
        step(1, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 8'h09, 1, 1);
            chk("rr_alt", 32'(bus.out_idx), (i % 2 == 0) ? 3 : 0);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h09, 0, 1);
            chk("rr_off", 32'(bus.out_idx), 3);
        end

        // Reset while a grant is held
        step(1, 8'h00, 0, 0);
        step(0, 8'h10, 1, 0);
        chk("mid_idx", 32'(bus.out_idx), 4);
        step(1, 8'h10, 1, 0);
        chk("mid_valid", 32'(bus.out_valid), 0);
        chk("mid_ptr", 32'(bus.ptr), 7);
        step(0, 8'h10, 1, 0);
        chk("mid_regrant", 32'(bus.out_idx), 4);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rq = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rq = 8'h00;
            step(($urandom_range(0, 50) == 0), rq, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
